// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NREQ byte producers.
// Requesters are served round-robin. Each grant produces a one-cycle tx_start
// with the latched byte, waits for tx_busy to rise and then fall, and
// optionally idles GAP_CYCLES clocks before the next grant.
//
// Optional feature: define UART_ARB_LOCK_EN to add req_last. While a granted
// byte had req_last=0 at launch, the next grant is locked to the same requester
// so multi-byte packets stay contiguous on the line.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester byte available
//   req_data   requester i byte at [i*DATA_W +: DATA_W]
//   req_last   (UART_ARB_LOCK_EN only) byte ends a packet
//   req_ready  one-hot pulse, byte of requester i consumed
//   tx_start   one-cycle launch pulse to the transmitter
//   tx_data    byte presented with tx_start, held until the next grant
//   tx_busy    transmitter frame in progress
//   grant_id   index of current/last granted requester
//   active     high from launch until the gap is done
module uart_tx_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DATA_W-1:0]  req_data,
`ifdef UART_ARB_LOCK_EN
   input  logic [NREQ-1:0]         req_last,
`endif
   output logic [NREQ-1:0]         req_ready,
   output logic                    tx_start,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    active
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StWaitBusy,
      StWaitDone,
      StGap
   } state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       grant_q, grant_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [GW-1:0]       gap_q, gap_d;

   logic                sel_found;
   logic [IW-1:0]       sel_idx;
   logic [IW-1:0]       cand;

`ifdef UART_ARB_LOCK_EN
   logic                lock_q, lock_d;
`endif

   // Round-robin search starting one past the last grant.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = grant_q;
      cand      = '0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         cand = IW'((32'(grant_q) + off) % NREQ);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
`ifdef UART_ARB_LOCK_EN
      // Mid-packet: only the owning requester may be granted.
      if (lock_q) begin
         sel_found = req_valid[grant_q];
         sel_idx   = grant_q;
      end
`endif
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      data_d    = data_q;
      gap_d     = gap_q;
      req_ready = '0;
      tx_start  = 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_d    = lock_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               grant_d = sel_idx;
               // Byte is captured at selection so a late valid drop cannot lose it.
               data_d  = DATA_W'(req_data >> (32'(sel_idx) * DATA_W));
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            tx_start           = 1'b1;
            req_ready[grant_q] = 1'b1;
`ifdef UART_ARB_LOCK_EN
            lock_d             = ~req_last[grant_q];
`endif
            state_d            = StWaitBusy;
         end
         StWaitBusy: begin
            if (tx_busy) state_d = StWaitDone;
         end
         StWaitDone: begin
            if (!tx_busy) begin
               if (GAP_CYCLES == 0) begin
                  state_d = StIdle;
               end else begin
                  gap_d   = GAP_LOAD;
                  state_d = StGap;
               end
            end
         end
         StGap: begin
            if (gap_q == '0) state_d = StIdle;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         grant_q <= IW'(NREQ - 1);
         data_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         gap_q   <= gap_d;
      end
   end

`ifdef UART_ARB_LOCK_EN
   always_ff @(posedge clk) begin
      if (rst) lock_q <= 1'b0;
      else     lock_q <= lock_d;
   end
`endif

   assign tx_data  = data_q;
   assign grant_id = grant_q;
   assign active   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
// One instance with GAP_CYCLES=0 carries most scenarios; a second instance with
// GAP_CYCLES=3 covers the inter-frame gap. Define UART_ARB_LOCK_EN to include
// the packet-lock scenario.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_last  = 4'b1111;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic [1:0]  grant_id;
   logic        active;

   logic [3:0]  g_valid = '0;
   logic [31:0] g_data  = '0;
   logic [3:0]  g_last  = 4'b1111;
   logic [3:0]  g_ready;
   logic        g_start;
   logic [7:0]  g_tx_data;
   logic        g_busy = 1'b0;
   logic [1:0]  g_grant;
   logic        g_active;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .GAP_CYCLES(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
`ifdef UART_ARB_LOCK_EN
      .req_last  (req_last),
`endif
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .grant_id  (grant_id),
      .active    (active)
   );

   uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .GAP_CYCLES(3)) dut_gap (
      .clk       (clk),
      .rst       (rst),
      .req_valid (g_valid),
      .req_data  (g_data),
`ifdef UART_ARB_LOCK_EN
      .req_last  (g_last),
`endif
      .req_ready (g_ready),
      .tx_start  (g_start),
      .tx_data   (g_tx_data),
      .tx_busy   (g_busy),
      .grant_id  (g_grant),
      .active    (g_active)
   );

   // Advance one clock; inputs are driven and outputs sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      req_data = {d3, d2, d1, d0};
   endtask

   // Wait for a launch, check it, then emulate a busy frame of busy_len cycles.
   // after_valid is applied once the launch cycle has passed.
   task automatic run_frame(input logic [1:0] exp_grant, input logic [7:0] exp_data,
                            input int busy_len, input logic [3:0] after_valid,
                            input string name);
      int         waited;
      logic [3:0] exp_rdy;
      waited  = 0;
      exp_rdy = 4'b0001 << exp_grant;
      while (tx_start !== 1'b1 && waited < 6) begin
         tick();
         waited++;
      end
      checks++;
      if (tx_start !== 1'b1) begin
         errors++;
         $display("FAIL %s launch: tx_start=%b, required 1 within 6 cycles", name, tx_start);
      end else begin
         checks++;
         if (grant_id !== exp_grant) begin
            errors++;
            $display("FAIL %s grant_id: got %0d, required %0d", name, grant_id, exp_grant);
         end
         checks++;
         if (tx_data !== exp_data) begin
            errors++;
            $display("FAIL %s tx_data: got %0h, required %0h", name, tx_data, exp_data);
         end
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s req_ready: got %b, required %b", name, req_ready, exp_rdy);
         end
      end
      tx_busy = 1'b1;
      tick();
      req_valid = after_valid;
      for (int i = 0; i < busy_len; i++) begin
         checks++;
         if (tx_start !== 1'b0 || req_ready !== 4'b0000 || active !== 1'b1) begin
            errors++;
            $display("FAIL %s busy cycle %0d: start=%b ready=%b active=%b, required 0 0000 1",
                     name, i, tx_start, req_ready, active);
         end
         if (i < busy_len - 1) tick();
      end
      tx_busy = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (tx_start !== 1'b0 || req_ready !== 4'b0000 || tx_data !== 8'h00 ||
          grant_id !== 2'd3 || active !== 1'b0) begin
         errors++;
         $display("FAIL reset: start=%b ready=%b data=%0h grant=%0d active=%b, required 0 0000 0 3 0",
                  tx_start, req_ready, tx_data, grant_id, active);
      end
      checks++;
      if (g_grant !== 2'd3 || g_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_gap: grant=%0d active=%b, required 3 0", g_grant, g_active);
      end
   endtask

   task automatic test_single();
      apply_reset();
      set_data(8'h00, 8'h00, 8'h55, 8'h00);
      req_valid = 4'b0100;
      tick();
      checks++;
      if (tx_start !== 1'b1 || req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL single launch: start=%b ready=%b, required 1 0100", tx_start, req_ready);
      end
      checks++;
      if (grant_id !== 2'd2 || tx_data !== 8'h55) begin
         errors++;
         $display("FAIL single byte: grant=%0d data=%0h, required 2 55", grant_id, tx_data);
      end
      tx_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) req_data[23:16] = 8'h66;
         checks++;
         if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single busy %0d: start=%b ready=%b, required 0 0000",
                     i, tx_start, req_ready);
         end
      end
      tx_busy = 1'b0;
      tick();
      checks++;
      if (tx_start !== 1'b0 || active !== 1'b0) begin
         errors++;
         $display("FAIL single idle: start=%b active=%b, required 0 0", tx_start, active);
      end
      tick();
      checks++;
      if (tx_start !== 1'b1 || grant_id !== 2'd2 || tx_data !== 8'h66) begin
         errors++;
         $display("FAIL single second: start=%b grant=%0d data=%0h, required 1 2 66",
                  tx_start, grant_id, tx_data);
      end
      req_valid = 4'b0000;
      tx_busy   = 1'b1;
      tick();
      tick();
      tx_busy = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      req_valid = 4'b1111;
      apply_reset();
      run_frame(2'd0, 8'hA0, 4, 4'b1111, "rr0");
      run_frame(2'd1, 8'hA1, 4, 4'b1111, "rr1");
      run_frame(2'd2, 8'hA2, 4, 4'b1111, "rr2");
      run_frame(2'd3, 8'hA3, 4, 4'b1111, "rr3");
      run_frame(2'd0, 8'hA0, 4, 4'b0000, "rr4");
   endtask

   task automatic test_gap();
      apply_reset();
      g_data  = {8'h00, 8'h00, 8'hC1, 8'hC0};
      g_valid = 4'b0011;
      tick();
      checks++;
      if (g_start !== 1'b1 || g_grant !== 2'd0 || g_tx_data !== 8'hC0) begin
         errors++;
         $display("FAIL gap first: start=%b grant=%0d data=%0h, required 1 0 c0",
                  g_start, g_grant, g_tx_data);
      end
      g_busy = 1'b1;
      tick();
      g_valid = 4'b0010;
      tick();
      tick();
      tick();
      g_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (g_active !== 1'b1 || g_start !== 1'b0) begin
            errors++;
            $display("FAIL gap cycle %0d: active=%b start=%b, required 1 0", i, g_active, g_start);
         end
      end
      tick();
      checks++;
      if (g_active !== 1'b0 || g_start !== 1'b0) begin
         errors++;
         $display("FAIL gap idle: active=%b start=%b, required 0 0", g_active, g_start);
      end
      tick();
      checks++;
      if (g_start !== 1'b1 || g_grant !== 2'd1 || g_tx_data !== 8'hC1 || g_ready !== 4'b0010) begin
         errors++;
         $display("FAIL gap second: start=%b grant=%0d data=%0h ready=%b, required 1 1 c1 0010",
                  g_start, g_grant, g_tx_data, g_ready);
      end
      g_valid = 4'b0000;
   endtask

   task automatic test_reset_mid_frame();
      apply_reset();
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      req_valid = 4'b0100;
      tick();
      tx_busy = 1'b1;
      tick();
      req_valid = 4'b1111;
      tick();
      tick();
      checks++;
      if (active !== 1'b1 || grant_id !== 2'd2) begin
         errors++;
         $display("FAIL midrst setup: active=%b grant=%0d, required 1 2", active, grant_id);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (tx_start !== 1'b0 || req_ready !== 4'b0000 || tx_data !== 8'h00 ||
          grant_id !== 2'd3 || active !== 1'b0) begin
         errors++;
         $display("FAIL midrst values: start=%b ready=%b data=%0h grant=%0d active=%b, required 0 0000 0 3 0",
                  tx_start, req_ready, tx_data, grant_id, active);
      end
      rst     = 1'b0;
      tx_busy = 1'b0;
      tick();
      checks++;
      if (tx_start !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'hA0) begin
         errors++;
         $display("FAIL midrst first grant: start=%b grant=%0d data=%0h, required 1 0 a0",
                  tx_start, grant_id, tx_data);
      end
   endtask

   task automatic test_withdrawn();
      apply_reset();
      set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
      req_valid = 4'b0001;
      tick();
      checks++;
      if (tx_start !== 1'b1 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL withdraw launch0: start=%b grant=%0d, required 1 0", tx_start, grant_id);
      end
      tx_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) req_valid = 4'b1010;
         if (i == 4) req_valid = 4'b1000;
         if (i == 5) tx_busy = 1'b0;
         checks++;
         if (req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL withdraw ready1 cycle %0d: got %b, required 0", i, req_ready[1]);
         end
      end
      tick();
      tick();
      checks++;
      if (tx_start !== 1'b1 || grant_id !== 2'd3 || req_ready !== 4'b1000 || tx_data !== 8'hA3) begin
         errors++;
         $display("FAIL withdraw next: start=%b grant=%0d ready=%b data=%0h, required 1 3 1000 a3",
                  tx_start, grant_id, req_ready, tx_data);
      end
      req_valid = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (tx_start !== 1'b0 || active !== 1'b1) begin
            errors++;
            $display("FAIL stall cycle %0d: start=%b active=%b, required 0 1", i, tx_start, active);
         end
      end
      req_valid = 4'b0000;
   endtask

`ifdef UART_ARB_LOCK_EN
   task automatic test_lock();
      req_valid = 4'b0000;
      apply_reset();
      set_data(8'h10, 8'h11, 8'h00, 8'h00);
      req_last  = 4'b1101;
      req_valid = 4'b0001;
      run_frame(2'd0, 8'h10, 3, 4'b0011, "lock_pre");
      run_frame(2'd1, 8'h11, 3, 4'b0011, "lock_b1");
      req_data[15:8] = 8'h12;
      run_frame(2'd1, 8'h12, 3, 4'b0011, "lock_b2");
      req_data[15:8] = 8'h13;
      req_last       = 4'b1111;
      run_frame(2'd1, 8'h13, 3, 4'b0011, "lock_b3");
      run_frame(2'd0, 8'h10, 3, 4'b0000, "lock_after");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_gap();
      test_reset_mid_frame();
      test_withdrawn();
`ifdef UART_ARB_LOCK_EN
      test_lock();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NREQ byte-producing requesters.
- Per-requester valid/ready handshake; round-robin selection.
- Sequences the transmitter: one-cycle start pulse, waits out the busy frame, then an optional inter-frame gap.
- Sits between the control/datapath logic and the single TX serializer, which is driven from the same baud unit as the receiver.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- GAP_CYCLES, 0, idle clk cycles enforced after tx_busy falls before the next grant (0 = none).

Ports:
- clk, input, 1, single system clock; all logic on rising edge.
- rst, input, 1, synchronous, active-high reset.
- req_valid, input, NREQ, per-requester byte available.
- req_data, input, NREQ*DATA_W, requester i byte at [i*DATA_W +: DATA_W].
- req_ready, output, NREQ, one-hot pulse; byte of requester i consumed this cycle.
- tx_start, output, 1, one-cycle launch pulse to transmitter.
- tx_data, output, DATA_W, byte presented with tx_start; held until next launch.
- tx_busy, input, 1, transmitter frame in progress.
- grant_id, output, clog2(NREQ), index of current/last granted requester.
- active, output, 1, high from launch until gap done.

Behaviour:
- Reset (rst high at a clk edge): state IDLE; req_ready=0, tx_start=0, tx_data=0, grant_id=NREQ-1 (so requester 0 wins first), active=0, gap counter=0. Reset mid-frame aborts the sequence; the transmitter frame is not cancelled by this block.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any req_valid bit is set at edge k, select the first set bit searching grant_id+1, grant_id+2, … modulo NREQ. Register grant_id; go LAUNCH. If none is set, stay.
- LAUNCH (one cycle): tx_start=1; tx_data registered from the granted slice; req_ready[grant_id]=1; active=1. Next state is WAIT_BUSY.
- Handshake: a requester must hold req_valid and req_data stable until it sees req_ready. Dropping valid before grant is legal. If valid drops between selection and LAUNCH, the byte is still consumed (latched at selection).
- WAIT_BUSY: wait for tx_busy=1, then go WAIT_DONE. If tx_busy is already 1 in LAUNCH, go directly to WAIT_DONE after WAIT_BUSY's first cycle.
- WAIT_DONE: wait for tx_busy=0.
  - GAP_CYCLES=0: go IDLE.
  - Otherwise: load counter=GAP_CYCLES-1 and go GAP.
- GAP: decrement each cycle; at 0 go IDLE; active=0 on entering IDLE.
- Output timing: req_ready and tx_start are coincident single-cycle pulses, never back-to-back. Minimum spacing is 3 cycles plus the busy duration plus GAP_CYCLES.
- Fairness: a requester holding valid continuously waits at most NREQ-1 other grants.
- Requests arriving in non-IDLE states are not sampled until IDLE.

Optional Feature:
- Macro UART_ARB_LOCK_EN.
- Defined:
  - Adds input req_last[NREQ].
  - After a granted byte whose req_last bit was 0 at LAUNCH, the next IDLE evaluation grants the same requester only, skipping round-robin. It waits in IDLE if that requester is not valid.
  - The lock releases after a byte with req_last=1, or on rst.
  - This keeps multi-byte packets contiguous on the line.
- Undefined: port absent; every byte is arbitrated independently.

Test Plan:
- Single requester: rst 2 cycles; req_valid=4'b0100, data 0x55. Expect:
  - grant_id=2, tx_start and req_ready[2] pulse together one cycle after the valid edge, tx_data=0x55.
  - The model raises tx_busy for 10 cycles; no second tx_start until busy falls.
- Round-robin: all four valid, bytes 0xA0..0xA3 held until ready → grant order 0,1,2,3,0; tx_data sequence A0,A1,A2,A3,A0.
- Gap: GAP_CYCLES=3, two back-to-back requests. Expect exactly 3 idle cycles between tx_busy falling and IDLE, with the second tx_start one cycle after IDLE is entered.
- Reset mid-frame: assert rst during WAIT_DONE. Expect:
  - All outputs return to reset values next edge, and grant_id=3.
  - After release with req_valid=4'b1111, the first grant is 0.
- Withdrawn request: requester 1 drops valid before being selected → no req_ready[1] and the next valid requester is granted. Zero-width busy (tx_busy stays 0) → FSM stalls in WAIT_BUSY, no further tx_start.
- UART_ARB_LOCK_EN: requester 1 sends 3 bytes (last on the 3rd) while requester 0 is valid → grants 1,1,1, then 0.
